imm_ext_arbiter: RTL and testbench



---
 rtl/imm_ext_arbiter_if.sv | 39 +++
 rtl/imm_ext_arbiter.sv | 66 ++++++
 tb/tb_imm_ext_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/imm_ext_arbiter_if.sv
// Handshake bundle between the two immediate requesters, the shared extender and its consumer.
// The zext select lines exist only when ZERO_EXT_EN is defined.
interface imm_ext_arbiter_if #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
);
    logic             req0_valid;
    logic [IMM_W-1:0] req0_imm;
    logic             req0_ready;
    logic             req1_valid;
    logic [IMM_W-1:0] req1_imm;
    logic             req1_ready;
`ifdef ZERO_EXT_EN
    logic             req0_zext;
    logic             req1_zext;
`endif
    logic             out_valid;
    logic [OUT_W-1:0] out_val;
    logic             out_id;
    logic             out_ready;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_imm, req1_valid, req1_imm, out_ready,
`ifdef ZERO_EXT_EN
        input  req0_zext, req1_zext,
`endif
        output req0_ready, req1_ready, out_valid, out_val, out_id
    );

    // Requester / consumer side
    modport master (
        output req0_valid, req0_imm, req1_valid, req1_imm, out_ready,
`ifdef ZERO_EXT_EN
        output req0_zext, req1_zext,
`endif
        input  req0_ready, req1_ready, out_valid, out_val, out_id
    );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin share of one IMM_W->OUT_W immediate extender between ALU-immediate (0) and
// branch-offset (1) requesters, with one registered output stage. Define ZERO_EXT_EN for zext selects.
module imm_ext_arbiter #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    imm_ext_arbiter_if.slave  bus
);
    logic             ptr_reg;
    logic             out_valid_reg;
    logic [OUT_W-1:0] out_val_reg;
    logic             out_id_reg;

    logic             stage_free;
    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic [IMM_W-1:0] sel_imm;
    logic             sel_zext;
    logic             fill_bit;
    logic [OUT_W-1:0] ext_val;

    // Readies are gated by rst so they fall the moment reset asserts, not at the next edge.
    always_comb begin
        stage_free = !out_valid_reg || bus.out_ready;
        grant0     = !rst && stage_free && bus.req0_valid && (!bus.req1_valid || !ptr_reg);
        grant1     = !rst && stage_free && bus.req1_valid && (!bus.req0_valid ||  ptr_reg);
        grant_any  = grant0 || grant1;
    end

    always_comb begin
        sel_imm  = grant1 ? bus.req1_imm : bus.req0_imm;
`ifdef ZERO_EXT_EN
        sel_zext = grant1 ? bus.req1_zext : bus.req0_zext;
`else
        sel_zext = 1'b0;
`endif
        fill_bit = sel_zext ? 1'b0 : sel_imm[IMM_W-1];
        ext_val  = {{(OUT_W-IMM_W){fill_bit}}, sel_imm};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_val_reg   <= '0;
            out_id_reg    <= 1'b0;
        end else if (grant_any) begin
            // Drain and refill on the same edge keeps one result per cycle.
            ptr_reg       <= grant0;
            out_valid_reg <= 1'b1;
            out_val_reg   <= ext_val;
            out_id_reg    <= grant1;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_val    = out_val_reg;
    assign bus.out_id     = out_id_reg;
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter: reset, extension, fairness, stall, async reset, lone requester.
module tb_imm_ext_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    imm_ext_arbiter_if #(.IMM_W(16), .OUT_W(32)) bus ();

    imm_ext_arbiter #(.IMM_W(16), .OUT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdy(input string tag, input logic e0, input logic e1);
        chk({tag, ".ready0"}, {31'd0, bus.req0_ready}, {31'd0, e0});
        chk({tag, ".ready1"}, {31'd0, bus.req1_ready}, {31'd0, e1});
    endtask

    task automatic res(input string tag, input logic ev, input logic [31:0] val, input logic id);
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, ev});
        chk({tag, ".val"},   bus.out_val, val);
        chk({tag, ".id"},    {31'd0, bus.out_id}, {31'd0, id});
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_imm = '0;
        bus.req1_valid = 1'b0; bus.req1_imm = '0;
`ifdef ZERO_EXT_EN
        bus.req0_zext = 1'b0; bus.req1_zext = 1'b0;
`endif
        bus.out_ready = 1'b0;
        #12;
        bus.req0_valid = 1'b1;
        #1;
        res("reset", 1'b0, 32'h0, 1'b0);
        rdy("reset", 1'b0, 0);
        $display("[TB] reset state checked");

        // Single request, sign-extended
        rst = 1'b0;
        bus.req0_imm = 16'h8001;
        #1;
        rdy("single", 1'b1, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        res("single", 1'b1, 32'hFFFF8001, 1'b0);
        $display("[TB] single req0 8001 -> %h id %0d", bus.out_val, bus.out_id);

        // Pointer is now 1: a lone req1 drains the result and returns the pointer to 0
        bus.out_ready  = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_imm = 16'hFFFE;
        #1;
        rdy("lone1", 1'b0, 1'b1);
        tick();
        res("lone1", 1'b1, 32'hFFFFFFFE, 1'b1);
        $display("[TB] lone req1 FFFE -> %h id %0d", bus.out_val, bus.out_id);

        // Fairness with both valid
        bus.req0_valid = 1'b1; bus.req0_imm = 16'h7FFF;
        for (int i = 0; i < 4; i++) begin
            logic w;
            w = i[0];
            #1;
            rdy($sformatf("rr%0d", i), !w, w);
            tick();
            res($sformatf("rr%0d", i), 1'b1, w ? 32'hFFFFFFFE : 32'h00007FFF, w);
            $display("[TB] round-robin %0d -> %h id %0d", i, bus.out_val, bus.out_id);
        end

        // Stall holds the result and blocks both requesters
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
            tick();
            res($sformatf("stall%0d", i), 1'b1, 32'hFFFFFFFE, 1'b1);
            $display("[TB] stall %0d holds %h id %0d", i, bus.out_val, bus.out_id);
        end
        bus.out_ready = 1'b1;
        #1;
        rdy("unstall", 1'b1, 1'b0);
        tick();
        res("unstall", 1'b1, 32'h00007FFF, 1'b0);
        $display("[TB] unstall -> %h id %0d", bus.out_val, bus.out_id);

        // Async reset while a stalled result is pending (pointer is 1 here)
        bus.out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        res("arst", 1'b0, 32'h0, 1'b0);
        rdy("arst", 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        rdy("post_rst", 1'b1, 1'b0);
        tick();
        res("post_rst", 1'b1, 32'h00007FFF, 1'b0);
        $display("[TB] async reset then grant -> %h id %0d", bus.out_val, bus.out_id);

        // Lone requester 1 back-to-back (pointer is 1 now, but alone it wins regardless)
        bus.out_ready  = 1'b1;
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [15:0] imm_v;
            logic [31:0] exp_v;
            case (i)
                0:       begin imm_v = 16'h0001; exp_v = 32'h00000001; end
                1:       begin imm_v = 16'h8000; exp_v = 32'hFFFF8000; end
                default: begin imm_v = 16'h1234; exp_v = 32'h00001234; end
            endcase
            bus.req1_imm = imm_v;
            #1;
            rdy($sformatf("b2b%0d", i), 1'b0, 1'b1);
            tick();
            res($sformatf("b2b%0d", i), 1'b1, exp_v, 1'b1);
            $display("[TB] back-to-back req1 %h -> %h id %0d", imm_v, bus.out_val, bus.out_id);
        end
        bus.req0_valid = 1'b1;
        #1;
        rdy("after_b2b", 1'b1, 1'b0);
        tick();
        res("after_b2b", 1'b1, 32'h00007FFF, 1'b0);
        $display("[TB] both valid after req1 run -> id %0d", bus.out_id);

`ifdef ZERO_EXT_EN
        bus.req0_valid = 1'b0;
        bus.req1_imm   = 16'h8000;
        bus.req1_zext  = 1'b1;
        #1;
        rdy("zext1", 1'b0, 1'b1);
        tick();
        res("zext1", 1'b1, 32'h00008000, 1'b1);
        $display("[TB] zext=1 8000 -> %h", bus.out_val);
        bus.req1_zext = 1'b0;
        tick();
        res("zext0", 1'b1, 32'hFFFF8000, 1'b1);
        $display("[TB] zext=0 8000 -> %h", bus.out_val);
`endif

        // Drain with nobody requesting
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        rdy("drain", 1'b0, 1'b0);
        tick();
        chk("drain.valid", {31'd0, bus.out_valid}, 32'd0);
        $display("[TB] drain -> out_valid %0d", bus.out_valid);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
